domain_pwr_seq: RTL and testbench

Per-domain power-up/power-down sequencer placed directly downstream of the SoC control register block and PLL. It consumes a software on/off request and the domain PLL lock flag, and produces an ordered clock-enable and active-low reset for one domain (core_0, core_1, sys_link). Bring-up order: PLL lock, then clock enable, then reset release. Shutdown order: reset assert, then clock stop. Status and a sticky error flag feed back into register readback.

---
 rtl/domain_pwr_seq_pkg.sv | 51 +++++
 rtl/domain_pwr_seq_if.sv | 23 ++
 rtl/domain_pwr_seq_sync_ff.sv | 28 ++
 rtl/domain_pwr_seq.sv | 114 +++++++++++
 tb/tb_domain_pwr_seq.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/domain_pwr_seq_pkg.sv
// Shared types for the per-domain power sequencer: state encoding and the
// per-state output decode used to load the registered outputs.
package domain_pwr_seq_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    ON        = 3'd3,
    DRAIN     = 3'd4,
    ERR       = 3'd5
  } pwr_seq_state_e;

  typedef struct packed {
    logic clk_en;
    logic rst_n;
    logic ready;
    logic busy;
  } pwr_seq_out_t;

  function automatic pwr_seq_out_t state_outputs(input pwr_seq_state_e s);
    pwr_seq_out_t o;
    o = '0;
    unique case (s)
      WAIT_LOCK: o.busy = 1'b1;
      SETTLE: begin
        o.clk_en = 1'b1;
        o.busy   = 1'b1;
      end
      ON: begin
        o.clk_en = 1'b1;
        o.rst_n  = 1'b1;
        o.ready  = 1'b1;
      end
      DRAIN: begin
        o.clk_en = 1'b1;
        o.busy   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/domain_pwr_seq_if.sv
// Control/status bundle between the register block (master) and the
// per-domain power sequencer (slave).
interface domain_pwr_seq_if;
  logic       on_req_i;
  logic       pll_locked_i;
  logic       err_clr_i;
  logic       clk_en_o;
  logic       rst_no;
  logic       ready_o;
  logic       busy_o;
  logic       err_o;
  logic [2:0] state_o;

  modport master (
    output on_req_i, pll_locked_i, err_clr_i,
    input  clk_en_o, rst_no, ready_o, busy_o, err_o, state_o
  );

  modport slave (
    input  on_req_i, pll_locked_i, err_clr_i,
    output clk_en_o, rst_no, ready_o, busy_o, err_o, state_o
  );
endinterface

// File: rtl/domain_pwr_seq_sync_ff.sv
// Reset-to-0 flop chain bringing the asynchronous PLL lock flag into clk_i.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/domain_pwr_seq.sv
// Per-domain power sequencer: orders clock enable and reset release on
// bring-up, reset assertion then clock stop on shutdown; sticky error flag.
module domain_pwr_seq
  import domain_pwr_seq_pkg::*;
#(
  parameter int unsigned LOCK_SYNC_STAGES = 2,
  parameter int unsigned LOCK_TIMEOUT     = 4096,
  parameter int unsigned CLK_SETTLE       = 16,
  parameter int unsigned RST_HOLD         = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  domain_pwr_seq_if.slave  pwr
);

  localparam int unsigned CNT_MAX = max3(LOCK_TIMEOUT, CLK_SETTLE, RST_HOLD);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CLK_SETTLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);

  pwr_seq_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwr_seq_out_t     out_q, out_d;
  logic             err_q, err_d;
  logic             err_set;
  logic             locked_s;

  sync_ff #(
    .STAGES (LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pwr.pll_locked_i),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      OFF: begin
        if (pwr.on_req_i) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!pwr.on_req_i) begin
          state_d = OFF;
        end else if (locked_s) begin
          state_d = SETTLE;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ERR;
          err_set = 1'b1;
        end
      end
      SETTLE: begin
        if (!pwr.on_req_i || !locked_s) begin
          state_d = DRAIN;
          err_set = !locked_s;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ON;
        end
      end
      ON: begin
        if (!pwr.on_req_i || !locked_s) begin
          state_d = DRAIN;
          err_set = !locked_s;
        end
      end
      DRAIN: begin
        if (cnt_q == HOLD_LAST) state_d = OFF;
      end
      ERR: begin
        if (!pwr.on_req_i) state_d = OFF;
      end
      default: state_d = OFF;
    endcase

    // Counter restarts on every transition and saturates rather than wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == WAIT_LOCK || state_q == SETTLE || state_q == DRAIN)
                 && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    out_d = state_outputs(state_d);
    err_d = err_set | (err_q & ~pwr.err_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign pwr.clk_en_o = out_q.clk_en;
  assign pwr.rst_no   = out_q.rst_n;
  assign pwr.ready_o  = out_q.ready;
  assign pwr.busy_o   = out_q.busy;
  assign pwr.err_o    = err_q;
  assign pwr.state_o  = state_q;

endmodule

// File: tb/tb_domain_pwr_seq.sv
// Directed bench for domain_pwr_seq: every edge's expected outputs are queued
// when stimulus is applied and compared one cycle later.
module tb_domain_pwr_seq;

  logic clk;
  logic rst_n;

  domain_pwr_seq_if bus ();

  domain_pwr_seq #(
    .LOCK_SYNC_STAGES (2),
    .LOCK_TIMEOUT     (8),
    .CLK_SETTLE       (16),
    .RST_HOLD         (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .pwr    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // Expected {clk_en, rst_n, ready, busy, err, state[2:0]} for a given state.
  function automatic logic [7:0] model(input int st, input logic e);
    logic [3:0] o;
    case (st)
      1:       o = 4'b0001;
      2:       o = 4'b1001;
      3:       o = 4'b1110;
      4:       o = 4'b1001;
      default: o = 4'b0000;
    endcase
    return {o, e, 3'(st)};
  endfunction

  task automatic step(input string tag, input int st, input logic e);
    logic [7:0] exp;
    logic [7:0] obs;
    exp_q.push_back(model(st, e));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    obs = {bus.clk_en_o, bus.rst_no, bus.ready_o, bus.busy_o, bus.err_o, bus.state_o};
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%b expected=%b (clk_en,rst_n,ready,busy,err,state)",
               tag, obs, exp);
      end
  endtask

  task automatic bringup(input string tag, input int n_wait, input logic e);
    for (int i = 0; i < n_wait; i++) step({tag, "_wait"}, 1, e);
    for (int i = 0; i < 16; i++) step({tag, "_settle"}, 2, e);
    step({tag, "_on"}, 3, e);
  endtask

  task automatic drain(input string tag, input logic e);
    for (int i = 0; i < 8; i++) step({tag, "_drain"}, 4, e);
    step({tag, "_off"}, 0, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.on_req_i     = 1'b1;
    bus.pll_locked_i = 1'b1;
    bus.err_clr_i    = 1'b0;

    step("reset0", 0, 1'b0);
    step("reset1", 0, 1'b0);
    rst_n        = 1'b1;
    bus.on_req_i = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 0, 1'b0);

    // Test 1: lock already present, full bring-up.
    bus.on_req_i = 1'b1;
    bringup("t1", 1, 1'b0);
    step("t1_hold", 3, 1'b0);

    // Test 3: orderly shutdown.
    bus.on_req_i = 1'b0;
    drain("t3", 1'b0);

    // Test 4: lock loss while on, automatic retry.
    bus.on_req_i = 1'b1;
    bringup("t4_up", 1, 1'b0);
    bus.pll_locked_i = 1'b0;
    step("t4_sync0", 3, 1'b0);
    step("t4_sync1", 3, 1'b0);
    drain("t4_loss", 1'b1);
    step("t4_retry", 1, 1'b1);
    bus.pll_locked_i = 1'b1;
    bringup("t4_relock", 2, 1'b1);
    bus.err_clr_i = 1'b1;
    step("t4_clr", 3, 1'b0);
    bus.err_clr_i = 1'b0;
    step("t4_on", 3, 1'b0);

    // Test 5: request dropped during settle.
    bus.on_req_i = 1'b0;
    drain("t5_pre", 1'b0);
    bus.on_req_i = 1'b1;
    step("t5_wait", 1, 1'b0);
    for (int i = 0; i < 5; i++) step("t5_settle", 2, 1'b0);
    bus.on_req_i = 1'b0;
    drain("t5", 1'b0);

    // Test 2: lock timeout.
    bus.pll_locked_i = 1'b0;
    step("t2_idle0", 0, 1'b0);
    step("t2_idle1", 0, 1'b0);
    bus.on_req_i = 1'b1;
    for (int i = 0; i < 8; i++) step("t2_wait", 1, 1'b0);
    step("t2_err", 5, 1'b1);
    step("t2_err_hold", 5, 1'b1);
    bus.on_req_i = 1'b0;
    step("t2_off", 0, 1'b1);
    bus.err_clr_i = 1'b1;
    step("t2_clr", 0, 1'b0);
    bus.err_clr_i = 1'b0;
    step("t2_idle", 0, 1'b0);

    // Test 6: clear coincident with timeout, then reset from ON.
    bus.on_req_i = 1'b1;
    for (int i = 0; i < 7; i++) step("t6_wait", 1, 1'b0);
    bus.err_clr_i = 1'b1;
    step("t6_wait_last", 1, 1'b0);
    step("t6_collide", 5, 1'b1);
    bus.err_clr_i = 1'b0;
    bus.on_req_i  = 1'b0;
    step("t6_off", 0, 1'b1);
    bus.pll_locked_i = 1'b1;
    bus.on_req_i     = 1'b1;
    bringup("t6_up", 2, 1'b1);
    rst_n = 1'b0;
    step("t6_rst", 0, 1'b0);
    rst_n = 1'b1;
    step("t6_post0", 1, 1'b0);
    step("t6_post1", 1, 1'b0);
    step("t6_post2", 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
